// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: running verdict
// encoding and receive FSM states.
package serial_cmp_pkg;

    typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;
    typedef enum logic {ST_IDLE, ST_SHIFT} scmp_state_t;

    // Verdict implied by a single differing bit-pair.
    function automatic cmp_res_t pair_verdict(input logic a_bit);
        return a_bit ? CMP_GT : CMP_LT;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cmp_bit_cell.sv
// One bit-step of the serial comparison: folds a bit-pair into the running
// decision, sticky for MSB-first streams and overwriting for LSB-first.
module cmp_bit_cell
    import serial_cmp_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  cmp_res_t i_dec,
    input  logic     i_a_bit,
    input  logic     i_b_bit,
    output cmp_res_t o_dec
);

    always_comb begin
        o_dec = i_dec;
        if (i_a_bit != i_b_bit) begin
            if ((MSB_FIRST == 0) || (i_dec == CMP_EQ)) begin
                o_dec = pair_verdict(i_a_bit);
            end
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator with sof framing; emits a
// registered one-hot EQ/GT/LT verdict with a one-cycle valid pulse.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic sof,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic result_valid,
    output logic eq,
    output logic gt,
    output logic lt,
    output logic frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    scmp_state_t   r_state;
    scmp_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    cmp_res_t      r_dec;
    cmp_res_t      w_dec_nxt;
    cmp_res_t      w_cell_in;
    cmp_res_t      w_cell_out;
    logic          w_start;
    logic          w_done;
    logic          w_ferr;
    logic          w_eq;
    logic          w_gt;
    logic          w_lt;

    // A sof bit always starts from EQ, so the one cell serves both paths.
    assign w_start   = bit_valid & sof;
    assign w_cell_in = w_start ? CMP_EQ : r_dec;
    assign w_cnt_inc = r_cnt + CNT_ONE;

    cmp_bit_cell #(
        .MSB_FIRST(MSB_FIRST)
    ) u_cell (
        .i_dec  (w_cell_in),
        .i_a_bit(a_bit),
        .i_b_bit(b_bit),
        .o_dec  (w_cell_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dec   <= CMP_EQ;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dec   <= w_dec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dec_nxt   = r_dec;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bit_valid) begin
                    if (sof) begin
                        w_dec_nxt = w_cell_out;
                        if (WIDTH == 1) begin
                            w_done    = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt   = CNT_ONE;
                            w_state_nxt = ST_SHIFT;
                        end
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (bit_valid) begin
                    w_dec_nxt = w_cell_out;
                    if (sof) begin
                        // Restart on the new sof bit; partial word is dropped.
                        w_ferr    = 1'b1;
                        w_cnt_nxt = CNT_ONE;
                    end else if (w_cnt_inc == CNT_LAST) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_dec_nxt   = CMP_EQ;
            end
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT);
        w_eq = (w_dec_nxt == CMP_EQ);
        w_gt = (w_dec_nxt == CMP_GT);
        w_lt = (w_dec_nxt == CMP_LT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            eq           <= 1'b0;
            gt           <= 1'b0;
            lt           <= 1'b0;
        end else begin
            result_valid <= w_done;
            frame_err    <= w_ferr;
            if (w_done) begin
                eq <= w_eq;
                gt <= w_gt;
                lt <= w_lt;
            end
        end
    end

endmodule
